mc_ctrl: RTL and testbench

- Main control FSM for the multicycle RV32I core; sequences the shared ALU, the memory and the register-file write port across fetch/decode/execute/writeback.
- Produces every datapath enable/select, including ImmSrc for the immediate extender and ALUControl for the ALU.
- Sits between the instruction register (op/funct fields) and the datapath, consuming ALU flags for branch resolution.

---
 rtl/mc_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// Main control FSM for the multicycle RV32I core: sequences fetch/decode/execute/writeback
// and drives every datapath enable and select, including ImmSrc and ALUControl.
module mc_ctrl #(
   parameter logic [3:0] RESET_STATE = 4'd0
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       Zero,
   input  logic       Neg,
   input  logic       Ovf,
   input  logic       Carry,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ALUControl,
   output logic [2:0] ImmSrc,
   output logic       RegWrite,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECR    = 4'd6,
      EXECI    = 4'd7,
      ALUWB    = 4'd8,
      BRANCH   = 4'd9,
      JAL      = 4'd10,
      JALR     = 4'd11,
      LUI      = 4'd12,
      AUIPC    = 4'd13,
      BAD14    = 4'd14,
      BAD15    = 4'd15
   } state_t;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_XOR = 3'b100,
      ALU_SLT = 3'b101
   } aluctl_t;

   state_t     state_q, state_d;
   logic       pcupdate, branch, taken;
   logic       irw_raw, mw_raw, rw_raw;
   logic [2:0] alu_funct;

   always_ff @(posedge clk) begin
      if (!reset_n) state_q <= state_t'(RESET_STATE);
      else          state_q <= state_d;
   end

   assign state = state_q;

   always_comb begin
      alu_funct = ALU_ADD;
      case (funct3)
         3'b000:  alu_funct = (funct7b5 & op[5]) ? ALU_SUB : ALU_ADD;
         3'b010:  alu_funct = ALU_SLT;
         3'b100:  alu_funct = ALU_XOR;
         3'b110:  alu_funct = ALU_OR;
         3'b111:  alu_funct = ALU_AND;
         default: alu_funct = ALU_ADD;
      endcase
   end

   // Carry is the no-borrow flag, so unsigned less-than is !Carry.
   always_comb begin
      taken = 1'b0;
      case (funct3)
         3'b000:  taken = Zero;
         3'b001:  taken = ~Zero;
         3'b100:  taken = Neg ^ Ovf;
         3'b101:  taken = ~(Neg ^ Ovf);
         3'b110:  taken = ~Carry;
         3'b111:  taken = Carry;
         default: taken = 1'b0;
      endcase
   end

   always_comb begin
      ImmSrc = 3'b000;
      case (op)
         7'b0000011, 7'b0010011, 7'b1100111: ImmSrc = 3'b000;
         7'b0100011:                         ImmSrc = 3'b001;
         7'b1100011:                         ImmSrc = 3'b010;
         7'b1101111:                         ImmSrc = 3'b011;
         7'b0110111, 7'b0010111:             ImmSrc = 3'b100;
         7'b0110011:                         ImmSrc = 3'b101;
         default:                            ImmSrc = 3'b000;
      endcase
   end

   always_comb begin
      state_d    = FETCH;
      pcupdate   = 1'b0;
      branch     = 1'b0;
      irw_raw    = 1'b0;
      mw_raw     = 1'b0;
      rw_raw     = 1'b0;
      AdrSrc     = 1'b0;
      ResultSrc  = 2'b00;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ALUControl = ALU_ADD;
      case (state_q)
         FETCH: begin
            state_d   = DECODE;
            irw_raw   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            pcupdate  = 1'b1;
         end
         DECODE: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
            case (op)
               7'b0000011, 7'b0100011: state_d = MEMADR;
               7'b0110011:             state_d = EXECR;
               7'b0010011:             state_d = EXECI;
               7'b1100011:             state_d = BRANCH;
               7'b1101111:             state_d = JAL;
               7'b1100111:             state_d = JALR;
               7'b0110111:             state_d = LUI;
               7'b0010111:             state_d = AUIPC;
               default:                state_d = FETCH;
            endcase
         end
         MEMADR: begin
            state_d = op[5] ? MEMWRITE : MEMREAD;
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
         end
         MEMREAD: begin
            state_d = MEMWB;
            AdrSrc  = 1'b1;
         end
         MEMWB: begin
            ResultSrc = 2'b01;
            rw_raw    = 1'b1;
         end
         MEMWRITE: begin
            AdrSrc = 1'b1;
            mw_raw = 1'b1;
         end
         EXECR: begin
            state_d    = ALUWB;
            ALUSrcA    = 2'b10;
            ALUControl = alu_funct;
         end
         EXECI: begin
            state_d    = ALUWB;
            ALUSrcA    = 2'b10;
            ALUSrcB    = 2'b01;
            ALUControl = alu_funct;
         end
         ALUWB: rw_raw = 1'b1;
         BRANCH: begin
            ALUSrcA    = 2'b10;
            ALUControl = ALU_SUB;
            branch     = 1'b1;
         end
         JAL: begin
            state_d  = ALUWB;
            ALUSrcA  = 2'b01;
            ALUSrcB  = 2'b10;
            pcupdate = 1'b1;
         end
         JALR: begin
            state_d = JAL;
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
         end
         LUI: begin
            state_d = ALUWB;
            ALUSrcA = 2'b11;
            ALUSrcB = 2'b01;
         end
         AUIPC: begin
            state_d = ALUWB;
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
         end
         default: state_d = FETCH;
      endcase
   end

   // Write enables are gated by reset so nothing commits while reset_n is low.
   assign PCWrite  = reset_n & (pcupdate | (branch & taken));
   assign IRWrite  = reset_n & irw_raw;
   assign MemWrite = reset_n & mw_raw;
   assign RegWrite = reset_n & rw_raw;

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: per-cycle expected outputs are queued when an
// instruction is driven and popped/compared on each falling edge.
module tb_mc_ctrl;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5, Zero, Neg, Ovf, Carry;
   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
   logic [2:0] ALUControl, ImmSrc;
   logic [3:0] state;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic [3:0] st;
      logic       pcw, adr, mw, irw, rw;
      logic [1:0] rs, sa, sb;
      logic [2:0] alu, imm;
   } exp_t;

   exp_t sb_q[$];

   mc_ctrl #(.RESET_STATE(4'd0)) dut (
      .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
      .Zero(Zero), .Neg(Neg), .Ovf(Ovf), .Carry(Carry),
      .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegWrite(RegWrite), .state(state)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic exp_t exp_for(input int unsigned st, input logic tk,
                                    input logic [2:0] alu, input logic [2:0] imm);
      exp_t e;
      e     = '0;
      e.st  = st[3:0];
      e.imm = imm;
      case (st)
         0:  begin e.irw = 1; e.pcw = 1; e.sb = 2'b10; e.rs = 2'b10; end
         1:  begin e.sa = 2'b01; e.sb = 2'b01; end
         2:  begin e.sa = 2'b10; e.sb = 2'b01; end
         3:  e.adr = 1;
         4:  begin e.rs = 2'b01; e.rw = 1; end
         5:  begin e.adr = 1; e.mw = 1; end
         6:  begin e.sa = 2'b10; e.alu = alu; end
         7:  begin e.sa = 2'b10; e.sb = 2'b01; e.alu = alu; end
         8:  e.rw = 1;
         9:  begin e.sa = 2'b10; e.alu = 3'b001; e.pcw = tk; end
         10: begin e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1; end
         11: begin e.sa = 2'b10; e.sb = 2'b01; end
         12: begin e.sa = 2'b11; e.sb = 2'b01; end
         13: begin e.sa = 2'b01; e.sb = 2'b01; end
         default: ;
      endcase
      return e;
   endfunction

   // Drive one instruction starting in FETCH; alu/imm/tk are the expected values
   // for this encoding, worked out by hand.
   task automatic run(input string name, input logic [6:0] o, input logic [2:0] f3,
                      input logic f7, input logic [3:0] zncv, input logic tk,
                      input logic [2:0] alu, input logic [2:0] imm);
      int unsigned seq[$];
      exp_t e;
      op = o; funct3 = f3; funct7b5 = f7;
      {Zero, Neg, Ovf, Carry} = zncv;
      case (o)
         7'b0000011: seq = '{0, 1, 2, 3, 4};
         7'b0100011: seq = '{0, 1, 2, 5};
         7'b0110011: seq = '{0, 1, 6, 8};
         7'b0010011: seq = '{0, 1, 7, 8};
         7'b1100011: seq = '{0, 1, 9};
         7'b1101111: seq = '{0, 1, 10, 8};
         7'b1100111: seq = '{0, 1, 11, 10, 8};
         7'b0110111: seq = '{0, 1, 12, 8};
         7'b0010111: seq = '{0, 1, 13, 8};
         default:    seq = '{0, 1};
      endcase
      foreach (seq[i]) sb_q.push_back(exp_for(seq[i], tk, alu, imm));
      while (sb_q.size() > 0) begin
         @(negedge clk);
         e = sb_q.pop_front();
         check_eq({name, ".state"}, state, e.st);
         check_eq({name, ".PCWrite"}, PCWrite, e.pcw);
         check_eq({name, ".IRWrite"}, IRWrite, e.irw);
         check_eq({name, ".MemWrite"}, MemWrite, e.mw);
         check_eq({name, ".RegWrite"}, RegWrite, e.rw);
         check_eq({name, ".AdrSrc"}, AdrSrc, e.adr);
         check_eq({name, ".ResultSrc"}, ResultSrc, e.rs);
         check_eq({name, ".ALUSrcA"}, ALUSrcA, e.sa);
         check_eq({name, ".ALUSrcB"}, ALUSrcB, e.sb);
         check_eq({name, ".ALUControl"}, ALUControl, e.alu);
         check_eq({name, ".ImmSrc"}, ImmSrc, e.imm);
         @(posedge clk); #1;
      end
   endtask

   initial begin
      reset_n = 1'b0; op = 7'b0100011; funct3 = '0; funct7b5 = 1'b0;
      Zero = 1'b0; Neg = 1'b0; Ovf = 1'b0; Carry = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk);
      check_eq("por.state", state, 4'd0);

      // Walk a store up to MEMWRITE, then hold reset there for three cycles.
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("rst.state", state, (i == 0) ? 4'd5 : 4'd0);
         check_eq("rst.PCWrite", PCWrite, 1'b0);
         check_eq("rst.IRWrite", IRWrite, 1'b0);
         check_eq("rst.MemWrite", MemWrite, 1'b0);
         check_eq("rst.RegWrite", RegWrite, 1'b0);
         @(posedge clk); #1;
      end
      reset_n = 1'b1;

      //   name      op          f3      f7    ZNVC     tk    alu     imm
      run("sub",    7'b0110011, 3'b000, 1'b1, 4'b0000, 1'b0, 3'b001, 3'b101);
      run("add",    7'b0110011, 3'b000, 1'b0, 4'b0000, 1'b0, 3'b000, 3'b101);
      run("slt",    7'b0110011, 3'b010, 1'b0, 4'b0000, 1'b0, 3'b101, 3'b101);
      run("and",    7'b0110011, 3'b111, 1'b0, 4'b0000, 1'b0, 3'b010, 3'b101);
      run("sll",    7'b0110011, 3'b001, 1'b1, 4'b0000, 1'b0, 3'b000, 3'b101);
      run("addi7",  7'b0010011, 3'b000, 1'b1, 4'b0000, 1'b0, 3'b000, 3'b000);
      run("xori",   7'b0010011, 3'b100, 1'b0, 4'b0000, 1'b0, 3'b100, 3'b000);
      run("ori",    7'b0010011, 3'b110, 1'b0, 4'b0000, 1'b0, 3'b011, 3'b000);
      run("lw",     7'b0000011, 3'b010, 1'b0, 4'b0000, 1'b0, 3'b000, 3'b000);
      run("sw",     7'b0100011, 3'b010, 1'b0, 4'b0000, 1'b0, 3'b000, 3'b001);
      run("bne_t",  7'b1100011, 3'b001, 1'b0, 4'b0000, 1'b1, 3'b000, 3'b010);
      run("bne_n",  7'b1100011, 3'b001, 1'b0, 4'b1000, 1'b0, 3'b000, 3'b010);
      run("beq_t",  7'b1100011, 3'b000, 1'b0, 4'b1000, 1'b1, 3'b000, 3'b010);
      run("blt_n",  7'b1100011, 3'b100, 1'b0, 4'b0110, 1'b0, 3'b000, 3'b010);
      run("blt_t",  7'b1100011, 3'b100, 1'b0, 4'b0100, 1'b1, 3'b000, 3'b010);
      run("bge_t",  7'b1100011, 3'b101, 1'b0, 4'b0110, 1'b1, 3'b000, 3'b010);
      run("bltu_t", 7'b1100011, 3'b110, 1'b0, 4'b0000, 1'b1, 3'b000, 3'b010);
      run("bgeu_t", 7'b1100011, 3'b111, 1'b0, 4'b0001, 1'b1, 3'b000, 3'b010);
      run("b010_n", 7'b1100011, 3'b010, 1'b0, 4'b1111, 1'b0, 3'b000, 3'b010);
      run("jalr",   7'b1100111, 3'b000, 1'b0, 4'b0000, 1'b0, 3'b000, 3'b000);
      run("jal",    7'b1101111, 3'b000, 1'b0, 4'b0000, 1'b0, 3'b000, 3'b011);
      run("lui",    7'b0110111, 3'b000, 1'b0, 4'b0000, 1'b0, 3'b000, 3'b100);
      run("auipc",  7'b0010111, 3'b000, 1'b0, 4'b0000, 1'b0, 3'b000, 3'b100);
      run("illegal",7'b1111111, 3'b000, 1'b0, 4'b0000, 1'b0, 3'b000, 3'b000);

      @(negedge clk);
      check_eq("end.state", state, 4'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
